// File: rtl/pwm_capture_pkg.sv
// Shared PWM definitions.
// This package holds the FSM state encoding used by pwm_capture. The PWM
// generator uses the same encoding. It also holds the per-cycle control word
// that the capture FSM hands to its datapath.
package pwm_capture_pkg;

  // Gray-style encoding: WAIT_RISE->HIGH->LOW flips one bit per step.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_RISE = 2'b01,
    ST_HIGH      = 2'b11,
    ST_LOW       = 2'b10
  } pwm_state_e;

  localparam int PWM_CNT_W_DEF = 8;

  // Datapath strobes decoded from the current state and the edge pulses.
  typedef struct packed {
    logic cnt_clr;   // clear counter (arming from IDLE)
    logic cnt_one;   // load counter with 1 (a rising edge opens a period)
    logic cnt_inc;   // saturating increment
    logic cap_high;  // latch counter into the high-time capture register
    logic meas_ok;   // publish period/high_width
    logic tmo;       // counter hit its limit without the expected edge
  } cap_ctrl_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement bus of pwm_capture.
//   start      : arm request (master -> slave)
//   pwm_in     : waveform under measurement (master -> slave)
//   high_width : high time of the last complete period, in clk cycles
//   period     : length of the last complete period, in clk cycles
//   done       : one-cycle pulse on a result or a timeout
//   busy       : measurement in progress
//   timeout    : sticky, counter saturated before the closing edge
interface pwm_capture_if #(
  parameter int B = 8
);
  logic         start;
  logic         pwm_in;
  logic [B-1:0] high_width;
  logic [B-1:0] period;
  logic         done;
  logic         busy;
  logic         timeout;

  modport master (
    output start, pwm_in,
    input  high_width, period, done, busy, timeout
  );

  modport slave (
    input  start, pwm_in,
    output high_width, period, done, busy, timeout
  );
endinterface

// File: rtl/pwm_capture_sync_edge_detect.sv
// Two-flop synchronizer followed by an edge-detect flop.
// This block is reusable by any module that needs clean edge pulses from an
// asynchronous input.
//   clk   : sampling clock
//   reset : asynchronous, active-low
//   din   : asynchronous input
//   rise  : one-cycle pulse after a 0->1 transition of din
//   fall  : one-cycle pulse after a 1->0 transition of din
// Both pulses are taken from the same pair of flops. This gives the two
// edges identical latency, so a measured width is exact.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_p0;
  logic din_p1;
  logic din_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_p0 <= 1'b0;
      din_p1 <= 1'b0;
      din_p2 <= 1'b0;
    end else begin
      // p0/p1: metastability settling; p2: previous synchronized value
      din_p0 <= din;
      din_p1 <= din_p0;
      din_p2 <= din_p1;
    end
  end

  assign rise = din_p1 & ~din_p2;
  assign fall = ~din_p1 & din_p2;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture.
// After start, the block waits for a rising edge of pwm_in. It then counts
// the clk cycles to the falling edge (high_width) and to the next rising
// edge (period).
// With CONTINUOUS=1, every closing edge also opens the next period, so a
// result is published once per PWM period until reset.
// The counter saturates at 2^B-1. Reaching that limit without the expected
// edge ends the run with timeout=1 and a done pulse. The previous results
// are kept.
//   clk         : clock
//   reset       : asynchronous, active-low
//   bus.start   : arm request, honoured only while idle
//   bus.pwm_in  : asynchronous PWM input
//   bus.high_width, bus.period : last complete measurement
//   bus.done    : registered one-cycle completion/timeout pulse
//   bus.busy    : not idle
//   bus.timeout : sticky until the next accepted start
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int B          = PWM_CNT_W_DEF,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  pwm_capture_if.slave  bus
);

  localparam logic [B-1:0] CNT_MAX = {B{1'b1}};
  localparam logic [B-1:0] CNT_LIM = {{(B-1){1'b1}}, 1'b0};
  localparam logic [B-1:0] CNT_ONE = {{(B-1){1'b0}}, 1'b1};

  function automatic logic [B-1:0] sat_inc(input logic [B-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic         rise;
  logic         fall;
  pwm_state_e   state;
  pwm_state_e   state_nxt;
  cap_ctrl_t    ctrl;
  logic         busy;
  logic         at_lim;
  logic [B-1:0] cnt;
  logic [B-1:0] high_cap;
  logic [B-1:0] high_width_r;
  logic [B-1:0] period_r;
  logic         done_r;
  logic         timeout_r;

  sync_edge_detect u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  // The next increment would reach saturation.
  assign at_lim = (cnt == CNT_LIM);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Edges that cannot terminate the current state are
  // ignored: a fall in WAIT_RISE/LOW, or a rise in HIGH.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (rise)        state_nxt = ST_HIGH;
        else if (at_lim) state_nxt = ST_IDLE;
      end
      ST_HIGH: begin
        if (fall)        state_nxt = ST_LOW;
        else if (at_lim) state_nxt = ST_IDLE;
      end
      ST_LOW: begin
        if (rise)        state_nxt = CONTINUOUS ? ST_HIGH : ST_IDLE;
        else if (at_lim) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    ctrl = '0;
    busy = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        ctrl.cnt_clr = bus.start;
      end
      ST_WAIT_RISE: begin
        if (rise) begin
          ctrl.cnt_one = 1'b1;
        end else begin
          ctrl.cnt_inc = 1'b1;
          ctrl.tmo     = at_lim;
        end
      end
      ST_HIGH: begin
        ctrl.cnt_inc = 1'b1;
        if (fall) ctrl.cap_high = 1'b1;
        else      ctrl.tmo      = at_lim;
      end
      ST_LOW: begin
        if (rise) begin
          ctrl.meas_ok = 1'b1;
          // In continuous mode this rise is cycle 1 of the next period.
          if (CONTINUOUS) ctrl.cnt_one = 1'b1;
          else            ctrl.cnt_inc = 1'b1;
        end else begin
          ctrl.cnt_inc = 1'b1;
          ctrl.tmo     = at_lim;
        end
      end
      default: ctrl = '0;
    endcase
  end

  // Counter, capture and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      high_cap     <= '0;
      high_width_r <= '0;
      period_r     <= '0;
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      if (ctrl.cnt_clr)      cnt <= '0;
      else if (ctrl.cnt_one) cnt <= CNT_ONE;
      else if (ctrl.cnt_inc) cnt <= sat_inc(cnt);

      if (ctrl.cap_high) high_cap <= cnt;

      if (ctrl.meas_ok) begin
        period_r     <= cnt;
        high_width_r <= high_cap;
      end

      done_r <= ctrl.meas_ok | ctrl.tmo;

      if (ctrl.cnt_clr)  timeout_r <= 1'b0;
      else if (ctrl.tmo) timeout_r <= 1'b1;
    end
  end

  assign bus.high_width = high_width_r;
  assign bus.period     = period_r;
  assign bus.done       = done_r;
  assign bus.busy       = busy;
  assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a single-shot instance and a continuous
// instance share the clock, reset and PWM source.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_capture_if #(.B(8)) ifs ();
  pwm_capture_if #(.B(8)) ifc ();

  pwm_capture #(.B(8), .CONTINUOUS(1'b0)) u_single (
    .clk   (clk),
    .reset (reset),
    .bus   (ifs.slave)
  );

  pwm_capture #(.B(8), .CONTINUOUS(1'b1)) u_cont (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;

  // PWM generator: gen_hi cycles high, gen_lo cycles low; phase restarts
  // (high first) whenever it is enabled.
  int   gen_hi  = 0;
  int   gen_lo  = 0;
  int   gen_cnt = 0;
  bit   gen_en  = 1'b0;
  logic pwm     = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!gen_en) begin
        pwm     = 1'b0;
        gen_cnt = 0;
      end else begin
        pwm     = (gen_cnt < gen_hi);
        gen_cnt = (gen_cnt + 1 >= gen_hi + gen_lo) ? 0 : gen_cnt + 1;
      end
      ifs.pwm_in = pwm;
      ifc.pwm_in = pwm;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input bit which);
    if (which) ifc.start = 1'b1; else ifs.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifs.start = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int max, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
      if (which ? ifc.done : ifs.done) ok = 1'b1;
    end
  endtask

  task automatic wait_pwm(input logic level, input int max, output bit ok);
    int c;
    c  = 0;
    ok = (pwm == level);
    while (!ok && c < max) begin
      @(posedge clk); #1;
      c++;
      if (pwm == level) ok = 1'b1;
    end
  endtask

  initial begin
    int cyc;
    bit ok;
    int extra;

    reset      = 1'b0;
    ifs.start  = 1'b0;
    ifc.start  = 1'b0;
    ifs.pwm_in = 1'b0;
    ifc.pwm_in = 1'b0;
    tick(3);
    chk("rst_high_width", ifs.high_width, 0);
    chk("rst_period",     ifs.period,     0);
    chk("rst_done",       ifs.done,       0);
    chk("rst_busy",       ifs.busy,       0);
    chk("rst_timeout",    ifs.timeout,    0);
    reset = 1'b1;
    tick(2);

    // 50/100 single shot
    gen_hi = 50; gen_lo = 50; gen_en = 1'b1;
    tick(5);
    pulse_start(1'b0);
    chk("s1_busy", ifs.busy, 1);
    wait_done(1'b0, 400, cyc, ok);
    chk("s1_done_seen",  ok, 1);
    chk("s1_high_width", ifs.high_width, 50);
    chk("s1_period",     ifs.period, 100);
    chk("s1_timeout",    ifs.timeout, 0);
    chk("s1_busy_at_done", ifs.busy, 0);
    tick(1);
    chk("s1_done_width", ifs.done, 0);
    chk("s1_busy_after", ifs.busy, 0);

    // 2 high / 3 low: narrowest exact pulse
    gen_en = 1'b0;
    tick(10);
    gen_hi = 2; gen_lo = 3; gen_en = 1'b1;
    tick(7);
    pulse_start(1'b0);
    wait_done(1'b0, 50, cyc, ok);
    chk("s6_done_seen",  ok, 1);
    chk("s6_high_width", ifs.high_width, 2);
    chk("s6_period",     ifs.period, 5);

    // No edges: timeout 255 cycles after entering WAIT_RISE
    gen_en = 1'b0;
    tick(10);
    pulse_start(1'b0);
    wait_done(1'b0, 300, cyc, ok);
    chk("s3_done_seen",  ok, 1);
    chk("s3_latency",    cyc, 255);
    chk("s3_timeout",    ifs.timeout, 1);
    chk("s3_high_width_kept", ifs.high_width, 2);
    chk("s3_period_kept",     ifs.period, 5);
    tick(1);
    chk("s3_done_width",     ifs.done, 0);
    chk("s3_busy_after",     ifs.busy, 0);
    chk("s3_timeout_sticky", ifs.timeout, 1);

    // start re-pulsed while in LOW must be ignored
    gen_hi = 50; gen_lo = 50; gen_en = 1'b1;
    tick(5);
    pulse_start(1'b0);
    chk("s5_timeout_cleared", ifs.timeout, 0);
    wait_pwm(1'b0, 300, ok);
    wait_pwm(1'b1, 300, ok);
    wait_pwm(1'b0, 300, ok);
    chk("s5_reached_low", ok, 1);
    tick(10);
    pulse_start(1'b0);
    chk("s5_busy_in_low", ifs.busy, 1);
    wait_done(1'b0, 200, cyc, ok);
    chk("s5_done_seen",  ok, 1);
    chk("s5_high_width", ifs.high_width, 50);
    chk("s5_period",     ifs.period, 100);
    extra = 0;
    repeat (250) begin
      tick(1);
      if (ifs.done) extra++;
    end
    chk("s5_extra_done", extra, 0);
    chk("s5_busy_after", ifs.busy, 0);

    // Asynchronous reset while in HIGH
    pulse_start(1'b0);
    wait_pwm(1'b0, 300, ok);
    wait_pwm(1'b1, 300, ok);
    chk("s4_reached_high", ok, 1);
    tick(10);
    chk("s4_busy_in_high", ifs.busy, 1);
    chk("s4_prev_width",   ifs.high_width, 50);
    reset = 1'b0;
    #1;
    chk("s4_high_width", ifs.high_width, 0);
    chk("s4_period",     ifs.period, 0);
    chk("s4_done",       ifs.done, 0);
    chk("s4_busy",       ifs.busy, 0);
    chk("s4_timeout",    ifs.timeout, 0);
    extra = 0;
    repeat (4) begin
      tick(1);
      if (ifs.done) extra++;
    end
    reset = 1'b1;
    repeat (10) begin
      tick(1);
      if (ifs.done) extra++;
    end
    chk("s4_no_done", extra, 0);
    pulse_start(1'b0);
    wait_done(1'b0, 400, cyc, ok);
    chk("s4_done_seen",  ok, 1);
    chk("s4_high_width_after", ifs.high_width, 50);
    chk("s4_period_after",     ifs.period, 100);

    // Continuous 25/40 for three periods
    gen_en = 1'b0;
    tick(10);
    gen_hi = 25; gen_lo = 15; gen_en = 1'b1;
    tick(3);
    pulse_start(1'b1);
    wait_done(1'b1, 200, cyc, ok);
    chk("s2_done0_seen",  ok, 1);
    chk("s2_high_width0", ifc.high_width, 25);
    chk("s2_period0",     ifc.period, 40);
    for (int k = 1; k < 3; k++) begin
      wait_done(1'b1, 100, cyc, ok);
      chk("s2_done_seen",  ok, 1);
      chk("s2_interval",   cyc, 40);
      chk("s2_high_width", ifc.high_width, 25);
      chk("s2_period",     ifc.period, 40);
      chk("s2_busy",       ifc.busy, 1);
    end
    tick(1);
    chk("s2_done_width", ifc.done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter B, default 8: width of the internal cycle counter and of the measurement outputs.
REQ-002 Parameter CONTINUOUS, default 0: 0 = single-shot measurement per start; 1 = re-measure every period until reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 start  input  1  arm request; sampled only in IDLE.
REQ-006 pwm_in  input  1  PWM waveform to measure; may be asynchronous to clk.
REQ-007 high_width  output  B  clk cycles pwm_in was high in the last complete period.
REQ-008 period  output  B  clk cycles between the two rising edges of the last complete period.
REQ-009 done  output  1  one-cycle pulse marking a completed measurement or a timeout.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 timeout  output  1  sticky flag set when the counter saturates before the closing edge.

Function
REQ-012 pwm_in SHALL pass through a two-flop synchronizer; a third flop SHALL provide rise/fall detect pulses, one cycle wide, with equal latency for both edges.
REQ-013 FSM states: IDLE, WAIT_RISE, HIGH, LOW.
REQ-014 IDLE: start=1 -> WAIT_RISE; counter cleared; timeout cleared; otherwise stay.
REQ-015 WAIT_RISE: counter increments each cycle; rise detect -> HIGH with counter loaded to 1.
REQ-016 HIGH: counter increments; fall detect -> LOW; high capture register loaded with the current counter value.
REQ-017 LOW: counter increments; rise detect -> period<=counter, high_width<=high capture register, done=1 on the next cycle.
REQ-018 After a measurement: CONTINUOUS=0 -> IDLE; CONTINUOUS=1 -> HIGH with counter loaded to 1 (the closing edge opens the next period).
REQ-019 Counter SHALL saturate at 2^B-1; if it reaches 2^B-1 in WAIT_RISE, HIGH or LOW without the terminating edge -> timeout=1, done pulses, -> IDLE; high_width/period unchanged.
REQ-020 high_width and period change only on a successful measurement; they hold their values between measurements.
REQ-021 start asserted while busy=1 SHALL be ignored.
REQ-022 A fall detect in WAIT_RISE or LOW, or a rise detect in HIGH, SHALL NOT occur; if it does, it SHALL be ignored.
REQ-023 done SHALL be registered; it is high for exactly one cycle per measurement or timeout.
REQ-024 Measured values are exact for edges separated by at least 2 clk cycles; narrower pulses are not guaranteed to be detected.

Reset
REQ-025 reset=0 SHALL asynchronously force state=IDLE, counter=0, high_width=0, period=0, done=0, busy=0, timeout=0, and all synchronizer flops=0.
REQ-026 Reset mid-measurement SHALL discard the partial measurement; no done pulse is issued.
REQ-027 After reset, the first accepted start begins a fresh measurement.

Structure
REQ-028 State encodings (IDLE=2'b00, WAIT_RISE=2'b01, HIGH=2'b11, LOW=2'b10) SHALL live in the shared PWM definitions header, shared with the PWM generator.
REQ-029 The synchronizer plus edge detector SHALL be a sub-module, sync_edge_detect (ports clk, reset, din, rise, fall), reusable across blocks.
REQ-030 The cycle counter and capture registers are local to pwm_capture; there is no separate counter sub-module.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- B=8, pwm_in from the PWM generator (PULSE_WIDTH=100, ACTIVE_WIDTH=50); start -> one done pulse; high_width=50, period=100; busy=0 afterwards.
- B=8, CONTINUOUS=1, 25/40 waveform for 3 periods -> done every 40 cycles; each result high_width=25, period=40.
- B=8, pwm_in held 0 after start -> timeout=1 and done pulse 255 cycles after WAIT_RISE entry; high_width/period keep their previous values.
- Reset deasserted-asserted (reset=0) while in HIGH -> all outputs 0 immediately; no done pulse; a later start yields a correct measurement.
- start pulsed again during LOW -> ignored; a single done pulse with correct values.
- 2-cycle high / 3-cycle low waveform -> high_width=2, period=5.
